// File: rtl/uart_tx_mmio.sv
// Store-fed 8N1 UART transmitter on the data bus; register reads are combinational, a store is visible after its edge.
// A store to a full FIFO is dropped and sets sticky overflow unless the transmitter pops on that same edge.

module uartTxFifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       iCLK,
  input  logic                       iRST,
  input  logic                       iPush,
  input  logic [WIDTH-1:0]           iPushDat,
  input  logic                       iPop,
  output logic [WIDTH-1:0]           oHeadDat,
  output logic                       oFull,
  output logic                       oEmpty,
  output logic [$clog2(DEPTH+1)-1:0] oCount
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [CW-1:0]    count;
  logic             popOk;
  logic             pushOk;

  assign oEmpty   = (count == '0);
  assign oFull    = (count == CW'(DEPTH));
  assign popOk    = iPop && !oEmpty;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign pushOk   = iPush && (!oFull || popOk);
  assign oHeadDat = mem[rdPtr];
  assign oCount   = count;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + AW'(1);
      if (popOk)  rdPtr <= rdPtr + AW'(1);
      if (pushOk && !popOk)      count <= count + CW'(1);
      else if (popOk && !pushOk) count <= count - CW'(1);
    end
  end

  always_ff @(posedge iCLK) begin
    if (pushOk) mem[wrPtr] <= iPushDat;
  end
endmodule

module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'hFF20_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [31:0] iEnd,
  input  logic [31:0] iDadoEscrita,
  input  logic        iEscMem,
  input  logic        iLeMem,
  output logic [31:0] oDado,
  output logic        oSel,
  output logic        oTx,
  output logic        oBusy
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState;

  txState        state;
  logic [BW-1:0] baudCnt;
  logic [2:0]    bitIdx;
  logic [7:0]    shiftReg;
  logic          txReg;
  logic          enable;
  logic          overflow;

  logic          hit;
  logic [1:0]    regSel;
  logic          pushReq;
  logic          ctrlWr;
  logic          popReq;
  logic          baudDone;
  logic          fsmBusy;
  logic [7:0]    fifoHead;
  logic          fifoFull;
  logic          fifoEmpty;
  logic [CW-1:0] fifoCount;
  logic [4:0]    countExt;
  logic [31:0]   rdDat;
  logic          unusedBits;

  assign hit        = (iEnd[31:4] == BASE_ADDR[31:4]);
  assign regSel     = iEnd[3:2];
  assign pushReq    = iEscMem && hit && (regSel == 2'd0);
  assign ctrlWr     = iEscMem && hit && (regSel == 2'd2);
  assign baudDone   = (baudCnt == '0);
  assign fsmBusy    = (state != IDLE);
  assign popReq     = enable && !fifoEmpty && ((state == IDLE) || ((state == STOP) && baudDone));
  assign countExt   = 5'(fifoCount);
  assign unusedBits = ^{iEnd[1:0], iDadoEscrita[31:8]};

  uartTxFifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .iCLK     (iCLK),
    .iRST     (iRST),
    .iPush    (pushReq),
    .iPushDat (iDadoEscrita[7:0]),
    .iPop     (popReq),
    .oHeadDat (fifoHead),
    .oFull    (fifoFull),
    .oEmpty   (fifoEmpty),
    .oCount   (fifoCount)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state    <= IDLE;
      baudCnt  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      txReg    <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (popReq) begin
            state    <= START;
            shiftReg <= fifoHead;
            txReg    <= 1'b0;
            baudCnt  <= BAUD_LOAD;
          end
        end
        START: begin
          if (baudDone) begin
            state   <= DATA;
            bitIdx  <= '0;
            txReg   <= shiftReg[0];
            baudCnt <= BAUD_LOAD;
          end else begin
            baudCnt <= baudCnt - BW'(1);
          end
        end
        DATA: begin
          if (baudDone) begin
            baudCnt <= BAUD_LOAD;
            if (bitIdx == 3'd7) begin
              state <= STOP;
              txReg <= 1'b1;
            end else begin
              bitIdx   <= bitIdx + 3'd1;
              shiftReg <= {1'b0, shiftReg[7:1]};
              txReg    <= shiftReg[1];
            end
          end else begin
            baudCnt <= baudCnt - BW'(1);
          end
        end
        STOP: begin
          // Chaining straight into the next start bit keeps back-to-back frames gapless.
          if (baudDone) begin
            if (popReq) begin
              state    <= START;
              shiftReg <= fifoHead;
              txReg    <= 1'b0;
              baudCnt  <= BAUD_LOAD;
            end else begin
              state <= IDLE;
              txReg <= 1'b1;
            end
          end else begin
            baudCnt <= baudCnt - BW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      enable   <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (ctrlWr) begin
        enable <= iDadoEscrita[0];
        if (iDadoEscrita[1]) overflow <= 1'b0;
      end
      if (pushReq && fifoFull && !popReq) overflow <= 1'b1;
    end
  end

  // STATUS.busy reports the shifter only; oBusy also counts bytes still queued.
  always_comb begin
    rdDat = '0;
    if (hit && iLeMem) begin
      case (regSel)
        2'd1:    rdDat = {23'd0, countExt, overflow, fsmBusy, fifoEmpty, fifoFull};
        2'd2:    rdDat = {31'd0, enable};
        default: rdDat = '0;
      endcase
    end
  end

  assign oDado = rdDat;
  assign oSel  = hit;
  assign oTx   = txReg;
  assign oBusy = fsmBusy || !fifoEmpty;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: frame-level reference model compared every cycle, plus hand-computed checks.
module tb_uart_tx_mmio;
  localparam int CPB = 4;
  localparam int DEPTH = 8;
  localparam logic [31:0] BASE = 32'hFF20_0000;
  localparam logic [27:0] BASE_HI = 28'hFF20000;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [31:0] iEnd;
  logic [31:0] iDadoEscrita;
  logic        iEscMem;
  logic        iLeMem;
  logic [31:0] oDado;
  logic        oSel;
  logic        oTx;
  logic        oBusy;

  int total = 0;
  int bad = 0;

  uart_tx_mmio #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .iCLK         (iCLK),
    .iRST         (iRST),
    .iEnd         (iEnd),
    .iDadoEscrita (iDadoEscrita),
    .iEscMem      (iEscMem),
    .iLeMem       (iLeMem),
    .oDado        (oDado),
    .oSel         (oSel),
    .oTx          (oTx),
    .oBusy        (oBusy)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus the position inside the frame on the wire.
  logic [7:0] mq[$];
  bit         mActive = 0;
  int         mPos = 0;
  logic [7:0] mByte = 8'h00;
  bit         mEn = 1;
  bit         mOvf = 0;

  function automatic logic frameBit(input logic [7:0] b, input int pos);
    int k;
    k = pos / CPB;
    if (k == 0) return 1'b0;
    else if (k >= 9) return 1'b1;
    else return b[k-1];
  endfunction

  task automatic modelStep();
    bit popNow;
    bit pushHit;
    bit ctrlHit;
    if (iRST) begin
      mq.delete();
      mActive = 0;
      mPos = 0;
      mEn = 1;
      mOvf = 0;
      return;
    end
    popNow  = mEn && (mq.size() > 0) && (!mActive || mPos == 10 * CPB - 1);
    pushHit = iEscMem && (iEnd[31:4] == BASE_HI) && (iEnd[3:2] == 2'd0);
    ctrlHit = iEscMem && (iEnd[31:4] == BASE_HI) && (iEnd[3:2] == 2'd2);
    if (popNow) begin
      mByte = mq.pop_front();
      mActive = 1;
      mPos = 0;
    end else if (mActive) begin
      if (mPos == 10 * CPB - 1) mActive = 0;
      else mPos++;
    end
    if (pushHit) begin
      if (mq.size() < DEPTH) mq.push_back(iDadoEscrita[7:0]);
      else mOvf = 1;
    end
    if (ctrlHit) begin
      mEn = iDadoEscrita[0];
      if (iDadoEscrita[1]) mOvf = 0;
    end
  endtask

  always @(posedge iCLK or posedge iRST) modelStep();

  always @(negedge iCLK) begin
    logic        expTx;
    logic        expSel;
    logic [31:0] expD;
    expTx = mActive ? frameBit(mByte, mPos) : 1'b1;
    expSel = (iEnd[31:4] == BASE_HI);
    expD = 32'd0;
    if (expSel && iLeMem) begin
      if (iEnd[3:2] == 2'd1) begin
        expD[0]   = (mq.size() == DEPTH);
        expD[1]   = (mq.size() == 0);
        expD[2]   = mActive;
        expD[3]   = mOvf;
        expD[8:4] = 5'(mq.size());
      end else if (iEnd[3:2] == 2'd2) begin
        expD[0] = mEn;
      end
    end
    check("cyc_tx", {31'd0, oTx}, {31'd0, expTx});
    check("cyc_busy", {31'd0, oBusy}, {31'd0, mActive || (mq.size() > 0)});
    check("cyc_sel", {31'd0, oSel}, {31'd0, expSel});
    check("cyc_dado", oDado, expD);
  end

  // Line receiver: samples mid-bit and collects decoded bytes.
  logic [7:0] rxQ[$];
  logic [7:0] expQ[$];

  always begin
    @(negedge iCLK);
    if (oTx === 1'b0 && iRST === 1'b0) begin
      logic [7:0] b;
      b = 8'h00;
      repeat (CPB / 2) @(negedge iCLK);
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(negedge iCLK);
        b[k] = oTx;
      end
      repeat (CPB) @(negedge iCLK);
      rxQ.push_back(b);
    end
  end

  task automatic checkRx(input string name);
    check({name, "_n"}, rxQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < rxQ.size(); i++)
      check($sformatf("%s_b%0d", name, i), {24'd0, rxQ[i]}, {24'd0, expQ[i]});
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] v);
    @(posedge iCLK); #1;
    iEnd = a; iDadoEscrita = v; iEscMem = 1'b1;
    @(posedge iCLK); #1;
    iEscMem = 1'b0; iEnd = 32'd0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] d, output logic s);
    @(posedge iCLK); #1;
    iEnd = a; iLeMem = 1'b1;
    @(negedge iCLK);
    d = oDado; s = oSel;
    @(posedge iCLK); #1;
    iLeMem = 1'b0; iEnd = 32'd0;
  endtask

  task automatic waitIdle(input int budget, input string name);
    int n;
    n = 0;
    while (oBusy !== 1'b0 && n < budget) begin
      @(negedge iCLK);
      n++;
    end
    check(name, {31'd0, oBusy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        s;
    logic [9:0]  pat55;
    int          lowCnt;
    pat55 = 10'b1010101010;
    iRST = 1'b1; iEnd = 32'd0; iDadoEscrita = 32'd0; iEscMem = 1'b0; iLeMem = 1'b0;
    repeat (3) @(posedge iCLK);
    #1 iRST = 1'b0;

    // Reset state
    @(negedge iCLK);
    check("rst_tx", {31'd0, oTx}, 32'd1);
    check("rst_busy", {31'd0, oBusy}, 32'd0);
    load(BASE + 32'h4, d, s);
    check("rst_status", d, 32'h002);
    load(BASE + 32'h8, d, s);
    check("rst_ctrl", d, 32'h001);

    // Single 0x55 frame
    rxQ.delete();
    store(BASE, 32'h55);
    for (int n = 0; n <= 41; n++) begin
      @(negedge iCLK);
      if (n == 0) check("f55_pre", {31'd0, oTx}, 32'd1);
      if (n >= 1 && n <= 40 && ((n - 1) % CPB) == 2)
        check($sformatf("f55_bit%0d", (n - 1) / CPB), {31'd0, oTx}, {31'd0, pat55[(n - 1) / CPB]});
      if (n == 40) check("f55_busy40", {31'd0, oBusy}, 32'd1);
      if (n == 41) check("f55_busy41", {31'd0, oBusy}, 32'd0);
    end
    expQ.delete(); expQ.push_back(8'h55);
    checkRx("rx55");

    // Back-to-back 0xA5, 0x3C
    rxQ.delete();
    @(posedge iCLK); #1;
    iEnd = BASE; iDadoEscrita = 32'hA5; iEscMem = 1'b1;
    @(posedge iCLK); #1;
    iDadoEscrita = 32'h3C;
    @(posedge iCLK); #1;
    iEscMem = 1'b0; iEnd = BASE + 32'h4; iLeMem = 1'b1;
    @(negedge iCLK);
    check("b2b_cnt_a", {27'd0, oDado[8:4]}, 32'd1);
    repeat (19) @(negedge iCLK);
    check("b2b_cnt_b", {27'd0, oDado[8:4]}, 32'd1);
    repeat (20) @(negedge iCLK);
    check("b2b_stop", {31'd0, oTx}, 32'd1);
    @(negedge iCLK);
    check("b2b_start2", {31'd0, oTx}, 32'd0);
    check("b2b_cnt_c", {27'd0, oDado[8:4]}, 32'd0);
    @(posedge iCLK); #1;
    iLeMem = 1'b0; iEnd = 32'd0;
    waitIdle(100, "b2b_idle");
    expQ.delete(); expQ.push_back(8'hA5); expQ.push_back(8'h3C);
    checkRx("rxb2b");

    // Disabled fill with overflow, then clear and drain
    rxQ.delete();
    store(BASE + 32'h8, 32'h0);
    for (int i = 0; i < 9; i++) store(BASE, 32'((i + 1) * 32'h11));
    load(BASE + 32'h4, d, s);
    check("ovf_status", d, 32'h089);
    check("ovf_tx", {31'd0, oTx}, 32'd1);
    load(BASE + 32'h7, d, s);
    check("ovf_status_lowbits", d, 32'h089);
    store(BASE + 32'h8, 32'h3);
    load(BASE + 32'h4, d, s);
    check("ovf_cleared", d, 32'h074);
    waitIdle(400, "drain_idle");
    expQ.delete();
    for (int i = 0; i < 8; i++) expQ.push_back(8'((i + 1) * 8'h11));
    checkRx("rxdrain");

    // Full FIFO with a pop on the same edge as a store
    rxQ.delete();
    store(BASE + 32'h8, 32'h0);
    for (int i = 0; i < 8; i++) store(BASE, 32'hE0 + 32'(i));
    @(posedge iCLK); #1;
    iEnd = BASE + 32'h8; iDadoEscrita = 32'h1; iEscMem = 1'b1;
    @(posedge iCLK); #1;
    iEnd = BASE; iDadoEscrita = 32'hEE;
    @(posedge iCLK); #1;
    iEscMem = 1'b0; iEnd = BASE + 32'h4; iLeMem = 1'b1;
    @(negedge iCLK);
    check("fullpop_status", oDado, 32'h085);
    @(posedge iCLK); #1;
    iLeMem = 1'b0; iEnd = 32'd0;
    waitIdle(450, "fullpop_idle");
    expQ.delete();
    for (int i = 0; i < 8; i++) expQ.push_back(8'hE0 + 8'(i));
    expQ.push_back(8'hEE);
    checkRx("rxfullpop");

    // Asynchronous reset mid-frame
    store(BASE, 32'hF0);
    store(BASE, 32'h0F);
    repeat (14) @(posedge iCLK);
    #1;
    check("prerst_tx", {31'd0, oTx}, 32'd0);
    iRST = 1'b1;
    #1;
    check("rst_mid_tx", {31'd0, oTx}, 32'd1);
    check("rst_mid_busy", {31'd0, oBusy}, 32'd0);
    repeat (3) @(posedge iCLK);
    #1 iRST = 1'b0;
    load(BASE + 32'h4, d, s);
    check("postrst_status", d, 32'h002);
    check("postrst_busy", {31'd0, oBusy}, 32'd0);
    lowCnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge iCLK);
      if (oTx !== 1'b1) lowCnt++;
    end
    check("postrst_quiet", lowCnt, 32'd0);
    rxQ.delete();

    // Decode of data, reserved and out-of-window reads; reserved store ignored
    load(BASE, d, s);
    check("rd_txdata", d, 32'd0);
    check("sel_txdata", {31'd0, s}, 32'd1);
    load(BASE + 32'hC, d, s);
    check("rd_resv", d, 32'd0);
    check("sel_resv", {31'd0, s}, 32'd1);
    load(32'h1234_5670, d, s);
    check("rd_miss", d, 32'd0);
    check("sel_miss", {31'd0, s}, 32'd0);
    load(32'hFF21_0004, d, s);
    check("rd_miss2", d, 32'd0);
    check("sel_miss2", {31'd0, s}, 32'd0);
    store(BASE + 32'hC, 32'hFF);
    load(BASE + 32'h8, d, s);
    check("resv_ctrl", d, 32'h001);
    load(BASE + 32'h4, d, s);
    check("resv_status", d, 32'h002);

    repeat (2) @(posedge iCLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
